// File: rtl/usb_pkg.sv
// Shared constants, state encoding and helpers for the USB configuration
// descriptor capture/stream path.
package usb_pkg;

   localparam logic [7:0]  DESC_CONFIGURATION  = 8'h02;
   localparam logic        PID_DATA0           = 1'b0;
   localparam logic        PID_DATA1           = 1'b1;
   localparam logic [15:0] CONFIG_DESC_MIN_LEN = 16'd9;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CAPTURE = 3'd1;
   localparam logic [2:0] ST_STREAM  = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_CAPTURE = ST_CAPTURE,
      S_STREAM  = ST_STREAM,
      S_DONE    = ST_DONE,
      S_ERROR   = ST_ERROR
   } state_e;

   function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/usb_desc_buffer_ram.sv
// Simple dual-port byte buffer: one write port, one registered read port.
// The array has no reset; read data holds its value while rd_en is low.
module usb_desc_buffer_ram #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/usb_config_desc_streamer.sv
// Captures the DATA stage of GET_DESCRIPTOR(Configuration) into a buffer,
// then replays the bytes to the descriptor parser as a valid/ready stream.
module usb_config_desc_streamer
   import usb_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 9,
   parameter int MAX_PKT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              rx_pkt_start,
   input  logic              rx_pid_data1,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_pkt_end,
   input  logic              rx_pkt_err,
   output logic [7:0]        desc_data,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              overflow,
   output logic [15:0]       total_length,
   output logic [ADDR_W:0]   stream_len,
   output state_e            dbg_state
);

   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] MAX_PKT_L = (ADDR_W+1)'(MAX_PKT);
   localparam logic [ADDR_W:0] IDX_TL_LO = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0] IDX_TL_HI = (ADDR_W+1)'(3);
   localparam logic [ADDR_W:0] IDX_HDR   = (ADDR_W+1)'(4);
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

   state_e          state, state_n;
   logic [ADDR_W:0] wr_ptr, pkt_base, pkt_len, rd_ptr, tx_cnt;
   logic            exp_toggle, discard, pkt_err, ram_vld;
   logic [7:0]      rd_data;

   logic            disc_c, err_c, byte_acc, mem_we, ovf_n;
   logic [ADDR_W:0] base_c, len_c, wr_ptr_n, pkt_len_n, sl_c;
   logic [15:0]     tl_n, wr_ptr_z;
   logic            cap_end, cap_complete, cap_bad;
   logic            hs, last_hs, load_out, rd_issue;

   // Packet bookkeeping; a byte coinciding with rx_pkt_end is counted before
   // the end-of-packet decision, so everything here is the post-byte view.
   always_comb begin
      disc_c    = rx_pkt_start ? (rx_pid_data1 != exp_toggle) : discard;
      err_c     = (rx_pkt_start ? 1'b0 : pkt_err) | rx_pkt_err;
      base_c    = rx_pkt_start ? wr_ptr : pkt_base;
      len_c     = rx_pkt_start ? '0 : pkt_len;
      byte_acc  = (state == S_CAPTURE) && rx_valid && !disc_c;
      mem_we    = byte_acc && (wr_ptr < DEPTH_L);
      wr_ptr_n  = wr_ptr + (ADDR_W+1)'(mem_we);
      pkt_len_n = len_c + (ADDR_W+1)'(byte_acc);
      ovf_n     = overflow | (byte_acc && !mem_we);
      tl_n      = total_length;
      if (mem_we && wr_ptr == IDX_TL_LO) tl_n[7:0]  = rx_data;
      if (mem_we && wr_ptr == IDX_TL_HI) tl_n[15:8] = rx_data;
      wr_ptr_z  = 16'(wr_ptr_n);
      sl_c      = (wr_ptr_n >= IDX_HDR) ? (ADDR_W+1)'(min_u16(wr_ptr_z, tl_n)) : wr_ptr_n;
      cap_end   = (state == S_CAPTURE) && rx_pkt_end && !err_c && !disc_c;
      cap_complete = cap_end && (((wr_ptr_n >= IDX_HDR) && (wr_ptr_z >= tl_n)) ||
                                 (pkt_len_n < MAX_PKT_L) || ovf_n);
      cap_bad   = cap_complete && ((16'(sl_c) < CONFIG_DESC_MIN_LEN) ||
                                   (tl_n < CONFIG_DESC_MIN_LEN));
   end

   // Stream handshake: a byte moves when desc_valid && desc_ready at a clk
   // edge; while desc_valid && !desc_ready, desc_data and desc_valid hold.
   // RAM output acts as the prefetch stage feeding the desc_* register.
   always_comb begin
      hs       = desc_valid && desc_ready;
      last_hs  = (state == S_STREAM) && hs && (tx_cnt == stream_len - ONE);
      load_out = ram_vld && (!desc_valid || desc_ready);
      rd_issue = (state == S_STREAM) && (rd_ptr < stream_len) && (!ram_vld || load_out);
   end

   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_CAPTURE;
            S_CAPTURE: if (cap_complete) state_n = cap_bad ? S_ERROR : S_STREAM;
            S_STREAM:  if (last_hs) state_n = S_DONE;
            default:   state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         pkt_base     <= '0;
         pkt_len      <= '0;
         rd_ptr       <= '0;
         tx_cnt       <= '0;
         exp_toggle   <= PID_DATA1;
         discard      <= 1'b0;
         pkt_err      <= 1'b0;
         ram_vld      <= 1'b0;
         desc_data    <= '0;
         desc_valid   <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         overflow     <= 1'b0;
         total_length <= '0;
         stream_len   <= '0;
      end else begin
         state <= state_n;
         if (abort) begin
            done       <= 1'b0;
            error      <= 1'b0;
            desc_valid <= 1'b0;
            ram_vld    <= 1'b0;
            rd_ptr     <= '0;
            tx_cnt     <= '0;
         end else begin
            case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (start) begin
                     wr_ptr       <= '0;
                     total_length <= '0;
                     overflow     <= 1'b0;
                     done         <= 1'b0;
                     error        <= 1'b0;
                     exp_toggle   <= PID_DATA1;
                  end
               end
               S_CAPTURE: begin
                  pkt_base     <= base_c;
                  pkt_len      <= pkt_len_n;
                  discard      <= disc_c;
                  pkt_err      <= err_c;
                  overflow     <= ovf_n;
                  total_length <= tl_n;
                  wr_ptr       <= (rx_pkt_end && err_c) ? base_c : wr_ptr_n;
                  if (cap_end) exp_toggle <= ~exp_toggle;
                  if (cap_complete) begin
                     stream_len <= sl_c;
                     error      <= cap_bad;
                     rd_ptr     <= '0;
                     tx_cnt     <= '0;
                     ram_vld    <= 1'b0;
                     desc_valid <= 1'b0;
                  end
               end
               S_STREAM: begin
                  if (load_out) begin
                     desc_data  <= rd_data;
                     desc_valid <= 1'b1;
                  end else if (hs) begin
                     desc_valid <= 1'b0;
                  end
                  ram_vld <= rd_issue | (ram_vld & ~load_out);
                  if (rd_issue) rd_ptr <= rd_ptr + ONE;
                  if (hs) tx_cnt <= tx_cnt + ONE;
                  if (last_hs) begin
                     done       <= 1'b1;
                     desc_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   usb_desc_buffer_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (rx_data),
      .rd_en   (rd_issue),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   assign busy      = (state == S_CAPTURE) || (state == S_STREAM);
   assign dbg_state = state;

endmodule

// File: tb/tb_usb_config_desc_streamer.sv
// Bench for usb_config_desc_streamer: drives control-IN data packets, keeps
// a byte-level expected queue and checks the replayed stream against it.
module tb_usb_config_desc_streamer;
   import usb_pkg::*;

   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk, rst_n, start, abort;
   logic              rx_pkt_start, rx_pid_data1, rx_valid, rx_pkt_end, rx_pkt_err;
   logic [7:0]        rx_data, desc_data;
   logic              desc_valid, desc_ready, busy, done, error, overflow;
   logic [15:0]       total_length;
   logic [ADDR_W:0]   stream_len;
   state_e            dbg_state;

   usb_config_desc_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_PKT(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .rx_pkt_start(rx_pkt_start), .rx_pid_data1(rx_pid_data1), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_pkt_end(rx_pkt_end), .rx_pkt_err(rx_pkt_err),
      .desc_data(desc_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .busy(busy), .done(done), .error(error), .overflow(overflow),
      .total_length(total_length), .stream_len(stream_len), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];
   logic [7:0] img [1024];
   int         model_wr, plan;
   logic       model_tog;

   int         rx_count, stream_cyc, first_cyc, last_cyc;
   bit         seen_stream, seen_valid, prev_stall;
   logic [7:0] prev_data;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (dbg_state == S_STREAM && !seen_stream) begin
         seen_stream = 1'b1;
         stream_cyc  = cyc;
      end
      if (prev_stall && dbg_state == S_STREAM) begin
         check_eq("hold_valid", desc_valid, 1);
         check_eq("hold_data", desc_data, prev_data);
      end
      if (desc_valid && !seen_valid) begin
         seen_valid = 1'b1;
         first_cyc  = cyc;
      end
      if (desc_valid && desc_ready) begin
         if (exp_q.size() == 0) check_eq("extra_byte", 1, 0);
         else check_eq("stream_byte", desc_data, exp_q.pop_front());
         rx_count++;
         last_cyc = cyc;
      end
      prev_stall = desc_valid && !desc_ready;
      prev_data  = desc_data;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_xfer(input int tl, input int plan_len);
      for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
      img[0] = 8'd9;
      img[1] = DESC_CONFIGURATION;
      img[2] = tl[7:0];
      img[3] = tl[15:8];
      exp_q.delete();
      model_wr    = 0;
      model_tog   = PID_DATA1;
      plan        = plan_len;
      rx_count    = 0;
      seen_stream = 1'b0;
      seen_valid  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_pkt(input logic pid, input int n, input int err_at);
      bit accept;
      accept = (pid == model_tog) && (err_at < 0);
      if (n == 0) begin
         rx_pkt_start = 1'b1; rx_pid_data1 = pid; rx_pkt_end = 1'b1;
         tick();
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(0, 7) == 0) begin
            rx_pkt_start = 1'b0; rx_valid = 1'b0; rx_pkt_end = 1'b0; rx_pkt_err = 1'b0;
            tick();
         end
         rx_pkt_start = (i == 0);
         rx_pid_data1 = pid;
         rx_valid     = 1'b1;
         rx_data      = accept ? img[model_wr + i] : 8'($urandom);
         rx_pkt_end   = (i == n - 1);
         rx_pkt_err   = (i == err_at);
         if (accept && (model_wr + i) < plan) exp_q.push_back(img[model_wr + i]);
         tick();
      end
      rx_pkt_start = 1'b0; rx_valid = 1'b0; rx_pkt_end = 1'b0; rx_pkt_err = 1'b0;
      tick();
      if (accept) begin
         model_wr  = model_wr + n;
         model_tog = ~model_tog;
      end
   endtask

   task automatic wait_end(input int mode, input int budget);
      int n;
      n = 0;
      while (!(done || error) && n < budget) begin
         case (mode)
            0:       desc_ready = 1'b1;
            1:       desc_ready = ~desc_ready;
            default: desc_ready = ($urandom_range(0, 3) != 0);
         endcase
         tick();
         n++;
      end
      check_eq("end_reached", done | error, 1);
      desc_ready = 1'b1;
   endtask

   task automatic wait_bytes(input int count, input int budget);
      int n;
      n = 0;
      desc_ready = 1'b1;
      while (rx_count < count && n < budget) begin
         tick();
         n++;
      end
      check_eq("bytes_reached", rx_count, count);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      rx_pkt_start = 1'b0; rx_pid_data1 = 1'b0; rx_data = '0;
      rx_valid = 1'b0; rx_pkt_end = 1'b0; rx_pkt_err = 1'b0; desc_ready = 1'b1;
      rx_count = 0; seen_stream = 1'b0; seen_valid = 1'b0; prev_stall = 1'b0;
      stream_cyc = 0; first_cyc = 0; last_cyc = 0; prev_data = '0;
      repeat (3) tick();
      check_eq("rst_valid", desc_valid, 0);
      check_eq("rst_data", desc_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_total_length", total_length, 0);
      check_eq("rst_stream_len", stream_len, 0);
      check_eq("rst_state", dbg_state, S_IDLE);
      rst_n = 1'b1;
      tick();

      // T1: 64B DATA1 + 18B DATA0, stray start mid-capture, ready held high
      begin_xfer(82, 82);
      send_pkt(PID_DATA1, 64, -1);
      check_eq("t1_busy_mid", busy, 1);
      start = 1'b1; tick(); start = 1'b0;
      send_pkt(PID_DATA0, 18, -1);
      wait_end(0, 300);
      check_eq("t1_done", done, 1);
      check_eq("t1_error", error, 0);
      check_eq("t1_stream_len", stream_len, 82);
      check_eq("t1_total_length", total_length, 82);
      check_eq("t1_count", rx_count, 82);
      check_eq("t1_first_latency", first_cyc - stream_cyc, 2);
      check_eq("t1_no_bubble", last_cyc - first_cyc + 1, 82);
      check_eq("t1_valid_low", desc_valid, 0);

      // T2/T3: retransmitted DATA1, corrupted DATA0, then clean DATA0
      begin_xfer(82, 82);
      send_pkt(PID_DATA1, 64, -1);
      send_pkt(PID_DATA1, 64, -1);
      check_eq("t2_still_capture", dbg_state, S_CAPTURE);
      send_pkt(PID_DATA0, 18, 10);
      check_eq("t3_still_capture", dbg_state, S_CAPTURE);
      send_pkt(PID_DATA0, 18, -1);
      wait_end(2, 400);
      check_eq("t3_done", done, 1);
      check_eq("t3_stream_len", stream_len, 82);
      check_eq("t3_count", rx_count, 82);
      check_eq("t3_queue_empty", exp_q.size(), 0);

      // T4: ready toggles every clock
      begin_xfer(40, 40);
      send_pkt(PID_DATA1, 40, -1);
      wait_end(1, 400);
      check_eq("t4_done", done, 1);
      check_eq("t4_count", rx_count, 40);
      check_eq("t4_valid_low", desc_valid, 0);
      check_eq("t4_queue_empty", exp_q.size(), 0);

      // T5: wTotalLength beyond the buffer truncates at DEPTH
      begin_xfer(600, 512);
      for (int p = 0; p < 9; p++) send_pkt(p[0] ? PID_DATA0 : PID_DATA1, 64, -1);
      wait_end(2, 2000);
      check_eq("t5_overflow", overflow, 1);
      check_eq("t5_stream_len", stream_len, 512);
      check_eq("t5_total_length", total_length, 600);
      check_eq("t5_done", done, 1);
      check_eq("t5_count", rx_count, 512);

      // T5b: 4-byte short capture is too small to be a descriptor
      begin_xfer(9, 0);
      send_pkt(PID_DATA1, 4, -1);
      wait_end(0, 50);
      check_eq("t5b_error", error, 1);
      check_eq("t5b_done", done, 0);
      check_eq("t5b_overflow", overflow, 0);
      check_eq("t5b_stream_len", stream_len, 4);
      check_eq("t5b_total_length", total_length, 9);
      check_eq("t5b_busy", busy, 0);
      check_eq("t5b_count", rx_count, 0);

      // bare ZLP as the first packet
      begin_xfer(9, 0);
      send_pkt(PID_DATA1, 0, -1);
      wait_end(0, 50);
      check_eq("zlp_error", error, 1);
      check_eq("zlp_stream_len", stream_len, 0);

      // T6: abort after 20 streamed bytes, then a clean capture
      begin_xfer(50, 50);
      send_pkt(PID_DATA1, 50, -1);
      wait_bytes(20, 200);
      abort = 1'b1; desc_ready = 1'b0;
      tick();
      abort = 1'b0;
      check_eq("t6_state_idle", dbg_state, S_IDLE);
      check_eq("t6_valid_low", desc_valid, 0);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_done", done, 0);
      tick();
      check_eq("t6_count", rx_count, 20);
      begin_xfer(30, 30);
      send_pkt(PID_DATA1, 30, -1);
      wait_end(2, 300);
      check_eq("t6_restart_done", done, 1);
      check_eq("t6_restart_count", rx_count, 30);
      check_eq("t6_restart_len", stream_len, 30);

      // reset while streaming
      begin_xfer(20, 20);
      send_pkt(PID_DATA1, 20, -1);
      wait_bytes(5, 100);
      rst_n = 1'b0;
      tick();
      check_eq("rst_mid_valid", desc_valid, 0);
      check_eq("rst_mid_state", dbg_state, S_IDLE);
      check_eq("rst_mid_total", total_length, 0);
      rst_n = 1'b1;
      exp_q.delete();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
